id_stage: RTL and testbench

- Instruction-decode stage, directly downstream of the fetch stage.
- Owns the IF/ID buffer, the 32x32 architectural register file, immediate generation and load-use hazard detection.
- Drives the registered ID/EX buffer consumed by the execute stage.
- Accepts the fetch stage's IR (0 = bubble), PC and predicted-branch flag; returns a stall request that holds PC and IF/ID.

---
 rtl/id_stage.sv | 223 ++++++++++++++++++++++
 tb/tb_id_stage.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module : id_stage - decode stage: IF/ID and ID/EX buffers, register file,
//          immediate generation and load-use hazard detection.   Rev 1.0
// ============================================================================
module id_stage #(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pipeline_en,
  input  logic            flush,
  input  logic [31:0]     if_ir,
  input  logic [XLEN-1:0] if_pc,
  input  logic            if_predicted_branch,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            wb_load_regfile,
  output logic            id_stall,
  output logic [31:0]     ir_id_ex,
  output logic [XLEN-1:0] pc_id_ex,
  output logic [XLEN-1:0] rs1_data_id_ex,
  output logic [XLEN-1:0] rs2_data_id_ex,
  output logic [XLEN-1:0] imm_id_ex,
  output logic [4:0]      rd_id_ex,
  output logic            load_regfile_id_ex,
  output logic            pred_id_ex
);

  localparam logic [6:0] c_op_reg   = 7'b0110011;
  localparam logic [6:0] c_op_imm   = 7'b0010011;
  localparam logic [6:0] c_op_load  = 7'b0000011;
  localparam logic [6:0] c_op_store = 7'b0100011;
  localparam logic [6:0] c_op_br    = 7'b1100011;
  localparam logic [6:0] c_op_jalr  = 7'b1100111;
  localparam logic [6:0] c_op_jal   = 7'b1101111;
  localparam logic [6:0] c_op_lui   = 7'b0110111;
  localparam logic [6:0] c_op_auipc = 7'b0010111;

  logic [31:0]     ifid_ir_q, ifid_ir_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic            ifid_pred_q, ifid_pred_d;

  logic [31:0]     ex_ir_q, ex_ir_d;
  logic [XLEN-1:0] ex_pc_q, ex_pc_d;
  logic [XLEN-1:0] ex_rs1_q, ex_rs1_d;
  logic [XLEN-1:0] ex_rs2_q, ex_rs2_d;
  logic [XLEN-1:0] ex_imm_q, ex_imm_d;
  logic [4:0]      ex_rd_q, ex_rd_d;
  logic            ex_lr_q, ex_lr_d;
  logic            ex_pred_q, ex_pred_d;

  logic [XLEN-1:0] rf_q [NUM_REGS];
  logic [XLEN-1:0] rf_d [NUM_REGS];

  logic [6:0]        opcode;
  logic [4:0]        rs1, rs2, rd;
  logic              use_rs1, use_rs2, writes_rd;
  logic signed [31:0] imm32;
  logic [XLEN-1:0]   rs1_val, rs2_val;
  logic              rf_we, bubble;

  assign opcode = ifid_ir_q[6:0];
  assign rs1    = ifid_ir_q[19:15];
  assign rs2    = ifid_ir_q[24:20];
  assign rd     = ifid_ir_q[11:7];
  assign rf_we  = wb_load_regfile & pipeline_en & (wb_rd != 5'd0);

  always_comb begin
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    writes_rd = 1'b0;
    imm32     = '0;
    case (opcode)
      c_op_reg:   begin use_rs1 = 1'b1; use_rs2 = 1'b1; writes_rd = 1'b1; end
      c_op_imm,
      c_op_load,
      c_op_jalr:  begin
        use_rs1   = 1'b1;
        writes_rd = 1'b1;
        imm32     = {{20{ifid_ir_q[31]}}, ifid_ir_q[31:20]};
      end
      c_op_store: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm32   = {{20{ifid_ir_q[31]}}, ifid_ir_q[31:25], ifid_ir_q[11:7]};
      end
      c_op_br:    begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm32   = {{19{ifid_ir_q[31]}}, ifid_ir_q[31], ifid_ir_q[7],
                   ifid_ir_q[30:25], ifid_ir_q[11:8], 1'b0};
      end
      c_op_lui,
      c_op_auipc: begin
        writes_rd = 1'b1;
        imm32     = {ifid_ir_q[31:12], 12'h000};
      end
      c_op_jal:   begin
        writes_rd = 1'b1;
        imm32     = {{11{ifid_ir_q[31]}}, ifid_ir_q[31], ifid_ir_q[19:12],
                     ifid_ir_q[20], ifid_ir_q[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  // Reads see a same-cycle writeback so WB -> ID needs no extra stall.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != 5'd0) rs1_val = (rf_we && wb_rd == rs1) ? wb_data : rf_q[rs1];
    if (rs2 != 5'd0) rs2_val = (rf_we && wb_rd == rs2) ? wb_data : rf_q[rs2];
  end

  always_comb begin
    id_stall = 1'b0;
    if (ex_ir_q[6:0] == c_op_load && ex_rd_q != 5'd0 && !flush)
      id_stall = (use_rs1 && rs1 == ex_rd_q) || (use_rs2 && rs2 == ex_rd_q);
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      rf_d[r] = rf_q[r];
      if (rf_we && wb_rd == 5'(r)) rf_d[r] = wb_data;
    end
    rf_d[0] = '0;
  end

  always_comb begin
    ifid_ir_d   = ifid_ir_q;
    ifid_pc_d   = ifid_pc_q;
    ifid_pred_d = ifid_pred_q;
    if (pipeline_en) begin
      if (flush) begin
        ifid_ir_d   = '0;
        ifid_pc_d   = if_pc;
        ifid_pred_d = 1'b0;
      end else if (!id_stall) begin
        ifid_ir_d   = if_ir;
        ifid_pc_d   = if_pc;
        ifid_pred_d = if_predicted_branch;
      end
    end
  end

  // An empty IF/ID slot travels on as an all-zero bubble, same as a squash.
  assign bubble = flush | id_stall | (ifid_ir_q == 32'h0);

  always_comb begin
    ex_ir_d   = ex_ir_q;
    ex_pc_d   = ex_pc_q;
    ex_rs1_d  = ex_rs1_q;
    ex_rs2_d  = ex_rs2_q;
    ex_imm_d  = ex_imm_q;
    ex_rd_d   = ex_rd_q;
    ex_lr_d   = ex_lr_q;
    ex_pred_d = ex_pred_q;
    if (pipeline_en) begin
      if (bubble) begin
        ex_ir_d   = '0;
        ex_pc_d   = '0;
        ex_rs1_d  = '0;
        ex_rs2_d  = '0;
        ex_imm_d  = '0;
        ex_rd_d   = '0;
        ex_lr_d   = 1'b0;
        ex_pred_d = 1'b0;
      end else begin
        ex_ir_d   = ifid_ir_q;
        ex_pc_d   = ifid_pc_q;
        ex_rs1_d  = rs1_val;
        ex_rs2_d  = rs2_val;
        ex_imm_d  = XLEN'(imm32);
        ex_rd_d   = rd;
        ex_lr_d   = writes_rd && (rd != 5'd0);
        ex_pred_d = ifid_pred_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_ir_q   <= '0;
      ifid_pc_q   <= '0;
      ifid_pred_q <= 1'b0;
      ex_ir_q     <= '0;
      ex_pc_q     <= '0;
      ex_rs1_q    <= '0;
      ex_rs2_q    <= '0;
      ex_imm_q    <= '0;
      ex_rd_q     <= '0;
      ex_lr_q     <= 1'b0;
      ex_pred_q   <= 1'b0;
      for (int r = 0; r < NUM_REGS; r++) rf_q[r] <= '0;
    end else begin
      ifid_ir_q   <= ifid_ir_d;
      ifid_pc_q   <= ifid_pc_d;
      ifid_pred_q <= ifid_pred_d;
      ex_ir_q     <= ex_ir_d;
      ex_pc_q     <= ex_pc_d;
      ex_rs1_q    <= ex_rs1_d;
      ex_rs2_q    <= ex_rs2_d;
      ex_imm_q    <= ex_imm_d;
      ex_rd_q     <= ex_rd_d;
      ex_lr_q     <= ex_lr_d;
      ex_pred_q   <= ex_pred_d;
      for (int r = 0; r < NUM_REGS; r++) rf_q[r] <= rf_d[r];
    end
  end

  assign ir_id_ex           = ex_ir_q;
  assign pc_id_ex           = ex_pc_q;
  assign rs1_data_id_ex     = ex_rs1_q;
  assign rs2_data_id_ex     = ex_rs2_q;
  assign imm_id_ex          = ex_imm_q;
  assign rd_id_ex           = ex_rd_q;
  assign load_regfile_id_ex = ex_lr_q;
  assign pred_id_ex         = ex_pred_q;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_id_stage - self-checking bench for id_stage.   Rev 1.0
// ============================================================================
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset, pipeline_en, flush, if_predicted_branch, wb_load_regfile;
  logic [31:0] if_ir, if_pc, wb_data;
  logic [4:0]  wb_rd;
  logic        id_stall, load_regfile_id_ex, pred_id_ex;
  logic [31:0] ir_id_ex, pc_id_ex, rs1_data_id_ex, rs2_data_id_ex, imm_id_ex;
  logic [4:0]  rd_id_ex;

  id_stage #(.NUM_REGS(32), .XLEN(32)) dut (
    .clk(clk), .reset(reset), .pipeline_en(pipeline_en), .flush(flush),
    .if_ir(if_ir), .if_pc(if_pc), .if_predicted_branch(if_predicted_branch),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_load_regfile(wb_load_regfile),
    .id_stall(id_stall), .ir_id_ex(ir_id_ex), .pc_id_ex(pc_id_ex),
    .rs1_data_id_ex(rs1_data_id_ex), .rs2_data_id_ex(rs2_data_id_ex),
    .imm_id_ex(imm_id_ex), .rd_id_ex(rd_id_ex),
    .load_regfile_id_ex(load_regfile_id_ex), .pred_id_ex(pred_id_ex)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_rf [32];
  logic [31:0] m_if_ir, m_if_pc;
  logic        m_if_pred;
  logic [31:0] m_ex_ir, m_ex_pc, m_ex_rs1, m_ex_rs2, m_ex_imm;
  logic [4:0]  m_ex_rd;
  logic        m_ex_lr, m_ex_pred;

  function automatic bit op_is(input logic [31:0] ir, input string name);
    case (name)
      "reg":   return ir[6:0] == 7'h33;
      "imm":   return ir[6:0] == 7'h13;
      "load":  return ir[6:0] == 7'h03;
      "store": return ir[6:0] == 7'h23;
      "br":    return ir[6:0] == 7'h63;
      "jalr":  return ir[6:0] == 7'h67;
      "jal":   return ir[6:0] == 7'h6F;
      "lui":   return ir[6:0] == 7'h37;
      "auipc": return ir[6:0] == 7'h17;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit uses_rs1(input logic [31:0] ir);
    return op_is(ir, "reg") || op_is(ir, "imm") || op_is(ir, "load") ||
           op_is(ir, "store") || op_is(ir, "br") || op_is(ir, "jalr");
  endfunction

  function automatic bit uses_rs2(input logic [31:0] ir);
    return op_is(ir, "reg") || op_is(ir, "store") || op_is(ir, "br");
  endfunction

  function automatic bit writes_rd(input logic [31:0] ir);
    return (op_is(ir, "lui") || op_is(ir, "auipc") || op_is(ir, "jal") ||
            op_is(ir, "jalr") || op_is(ir, "load") || op_is(ir, "imm") ||
            op_is(ir, "reg")) && ir[11:7] != 5'd0;
  endfunction

  function automatic logic [31:0] imm_of(input logic [31:0] ir);
    int v;
    v = 0;
    if (op_is(ir, "imm") || op_is(ir, "load") || op_is(ir, "jalr"))
      v = $signed(ir[31:20]);
    else if (op_is(ir, "store"))
      v = $signed({ir[31:25], ir[11:7]});
    else if (op_is(ir, "br"))
      v = $signed({ir[31], ir[7], ir[30:25], ir[11:8]}) * 2;
    else if (op_is(ir, "jal"))
      v = $signed({ir[31], ir[19:12], ir[20], ir[30:21]}) * 2;
    else if (op_is(ir, "lui") || op_is(ir, "auipc"))
      v = int'(ir[31:12]) * 4096;
    return v;
  endfunction

  function automatic logic [31:0] rf_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
    if (wb_load_regfile && pipeline_en && wb_rd == idx) return wb_data;
    return m_rf[idx];
  endfunction

  function automatic bit model_stall();
    if (!op_is(m_ex_ir, "load") || m_ex_rd == 5'd0 || flush) return 1'b0;
    return (uses_rs1(m_if_ir) && m_if_ir[19:15] == m_ex_rd) ||
           (uses_rs2(m_if_ir) && m_if_ir[24:20] == m_ex_rd);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_if_ir <= 0; m_if_pc <= 0; m_if_pred <= 0;
      m_ex_ir <= 0; m_ex_pc <= 0; m_ex_rs1 <= 0; m_ex_rs2 <= 0;
      m_ex_imm <= 0; m_ex_rd <= 0; m_ex_lr <= 0; m_ex_pred <= 0;
      for (int i = 0; i < 32; i++) m_rf[i] <= 0;
    end else if (pipeline_en) begin
      if (flush || model_stall() || m_if_ir == 0) begin
        m_ex_ir <= 0; m_ex_pc <= 0; m_ex_rs1 <= 0; m_ex_rs2 <= 0;
        m_ex_imm <= 0; m_ex_rd <= 0; m_ex_lr <= 0; m_ex_pred <= 0;
      end else begin
        m_ex_ir   <= m_if_ir;
        m_ex_pc   <= m_if_pc;
        m_ex_rs1  <= rf_read(m_if_ir[19:15]);
        m_ex_rs2  <= rf_read(m_if_ir[24:20]);
        m_ex_imm  <= imm_of(m_if_ir);
        m_ex_rd   <= m_if_ir[11:7];
        m_ex_lr   <= writes_rd(m_if_ir);
        m_ex_pred <= m_if_pred;
      end
      if (flush) begin
        m_if_ir <= 0; m_if_pc <= 0; m_if_pred <= 0;
      end else if (!model_stall()) begin
        m_if_ir <= if_ir; m_if_pc <= if_pc; m_if_pred <= if_predicted_branch;
      end
      if (wb_load_regfile && wb_rd != 5'd0) m_rf[wb_rd] <= wb_data;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_ir",    ir_id_ex,           m_ex_ir);
      chk("m_pc",    pc_id_ex,           m_ex_pc);
      chk("m_rs1",   rs1_data_id_ex,     m_ex_rs1);
      chk("m_rs2",   rs2_data_id_ex,     m_ex_rs2);
      chk("m_imm",   imm_id_ex,          m_ex_imm);
      chk("m_rd",    32'(rd_id_ex),      32'(m_ex_rd));
      chk("m_lr",    32'(load_regfile_id_ex), 32'(m_ex_lr));
      chk("m_pred",  32'(pred_id_ex),    32'(m_ex_pred));
      chk("m_stall", 32'(id_stall),      32'(model_stall()));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic feed(input logic [31:0] ir, input logic [31:0] pc);
    if_ir = ir;
    if_pc = pc;
  endtask

  logic [31:0] tbl_ir  [7] = '{32'hFFF00093, 32'h0020A223, 32'h123453B7, 32'h008000EF,
                               32'h80000297, 32'h00008067, 32'h0000000F};
  logic [31:0] tbl_imm [7] = '{32'hFFFFFFFF, 32'h00000004, 32'h12345000, 32'h00000008,
                               32'h80000000, 32'h00000000, 32'h00000000};
  logic        tbl_lr  [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    reset = 1; pipeline_en = 1; flush = 0; if_predicted_branch = 0;
    wb_load_regfile = 0; wb_rd = 0; wb_data = 0; if_ir = 0; if_pc = 0;
    tick();
    chk_on = 1'b1;
    tick();
    chk("rst_ir", ir_id_ex, 32'h0);
    chk("rst_stall", 32'(id_stall), 32'h0);
    chk("rst_lr", 32'(load_regfile_id_ex), 32'h0);
    reset = 0;

    // addi x1,x0,5; x1/x2 written via writeback alongside
    feed(32'h00500093, 32'h60);
    wb_load_regfile = 1; wb_rd = 1; wb_data = 32'h100;
    tick();
    feed(32'h0, 32'h0);
    wb_rd = 2; wb_data = 32'h22;
    tick();
    wb_load_regfile = 0;
    chk("addi_ir", ir_id_ex, 32'h00500093);
    chk("addi_pc", pc_id_ex, 32'h60);
    chk("addi_imm", imm_id_ex, 32'h5);
    chk("addi_rd", 32'(rd_id_ex), 32'h1);
    chk("addi_lr", 32'(load_regfile_id_ex), 32'h1);

    // writeback bypass on x3
    feed(32'h00018233, 32'h64);
    tick();
    feed(32'h0, 32'h0);
    wb_load_regfile = 1; wb_rd = 3; wb_data = 32'hDEADBEEF;
    tick();
    wb_load_regfile = 0;
    chk("byp_rs1", rs1_data_id_ex, 32'hDEADBEEF);
    chk("byp_rd", 32'(rd_id_ex), 32'h4);

    // write to x0 is ignored, even on the bypass path
    feed(32'h000004B3, 32'h68);
    tick();
    feed(32'h0, 32'h0);
    wb_load_regfile = 1; wb_rd = 0; wb_data = 32'h12345678;
    tick();
    wb_load_regfile = 0;
    chk("x0_rs1", rs1_data_id_ex, 32'h0);
    chk("x0_rs2", rs2_data_id_ex, 32'h0);

    feed(32'h00018233, 32'h6C);
    tick();
    feed(32'h0, 32'h0);
    tick();
    chk("x3_stored", rs1_data_id_ex, 32'hDEADBEEF);

    // load-use: lw x5,0(x1) ; add x6,x5,x2
    feed(32'h0000A283, 32'h80);
    tick();
    feed(32'h00228333, 32'h84);
    tick();
    chk("lu_stall", 32'(id_stall), 32'h1);
    chk("lu_lw", ir_id_ex, 32'h0000A283);
    feed(32'h00000013, 32'h88);
    tick();
    chk("lu_bubble", ir_id_ex, 32'h0);
    chk("lu_stall_gone", 32'(id_stall), 32'h0);
    tick();
    chk("lu_add_ir", ir_id_ex, 32'h00228333);
    chk("lu_add_rd", 32'(rd_id_ex), 32'h6);
    chk("lu_add_rs2", rs2_data_id_ex, 32'h22);
    feed(32'h0, 32'h0);
    tick();

    // load into x0 never stalls
    feed(32'h0000A003, 32'h90);
    tick();
    feed(32'h00200333, 32'h94);
    tick();
    chk("lx0_stall", 32'(id_stall), 32'h0);
    feed(32'h0, 32'h0);
    tick();
    chk("lx0_add_ir", ir_id_ex, 32'h00200333);

    // predicted beq x1,x2,-8
    feed(32'hFE208CE3, 32'hA0);
    if_predicted_branch = 1;
    tick();
    feed(32'h0, 32'h0);
    if_predicted_branch = 0;
    tick();
    chk("beq_imm", imm_id_ex, 32'hFFFFFFF8);
    chk("beq_pred", 32'(pred_id_ex), 32'h1);
    chk("beq_lr", 32'(load_regfile_id_ex), 32'h0);
    chk("beq_rs1", rs1_data_id_ex, 32'h100);

    // flush overrides a pending load-use stall
    feed(32'h0000A283, 32'hB0);
    tick();
    feed(32'h00228333, 32'hB4);
    tick();
    flush = 1;
    #1;
    chk("fl_stall", 32'(id_stall), 32'h0);
    tick();
    flush = 0;
    chk("fl_ir", ir_id_ex, 32'h0);
    feed(32'h0, 32'h0);
    tick();
    chk("fl_ifid_bubble", ir_id_ex, 32'h0);

    // freeze with a writeback pending
    feed(32'h00500093, 32'hC0);
    tick();
    feed(32'h000505B3, 32'hC4);
    tick();
    feed(32'h0, 32'h0);
    pipeline_en = 0;
    wb_load_regfile = 1; wb_rd = 10; wb_data = 32'hA5A5A5A5;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_ir", ir_id_ex, 32'h00500093);
    end
    pipeline_en = 1;
    tick();
    wb_load_regfile = 0;
    chk("frz_rel_ir", ir_id_ex, 32'h000505B3);
    chk("frz_rel_rs1", rs1_data_id_ex, 32'hA5A5A5A5);
    feed(32'h000505B3, 32'hC8);
    tick();
    feed(32'h0, 32'h0);
    tick();
    chk("frz_stored", rs1_data_id_ex, 32'hA5A5A5A5);

    // immediate formats, back-to-back
    for (int i = 0; i < 7; i++) begin
      feed(tbl_ir[i], 32'h100 + 32'(i * 4));
      tick();
      if (i > 0) begin
        chk("tbl_imm", imm_id_ex, tbl_imm[i-1]);
        chk("tbl_lr", 32'(load_regfile_id_ex), 32'(tbl_lr[i-1]));
      end
    end
    feed(32'h0, 32'h0);
    tick();
    chk("tbl_imm", imm_id_ex, tbl_imm[6]);
    chk("tbl_lr", 32'(load_regfile_id_ex), 32'(tbl_lr[6]));
    tick();
    tick();

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
